// File: rtl/bsearch_lookup_pkg.sv
// Shared definitions for the binary-search lookup block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bsearch_lookup_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bsearch_lookup_search.sv
// Binary search FSM over a constant ascending ROM (rom[i] = i+1).
// Latency: 1 cycle to latch the key, then at most 6 search cycles.
// Backpressure: result held in DONE until start drops.
module binary_search
    import bsearch_lookup_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic [ADDR_W-1:0] addr,
    output logic              found,
    output logic              notfound
);

    localparam logic [ADDR_W-1:0] TOP_IDX = {ADDR_W{1'b1}};

    state_t            state, state_n;
    logic [DATA_W-1:0] key, key_n;
    logic [ADDR_W-1:0] low, low_n, high, high_n, addr_n;
    logic              found_n, notfound_n;
    logic [ADDR_W:0]   mid_sum;
    logic [ADDR_W-1:0] mid;
    logic [DATA_W-1:0] rom_val;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] idx);
        return DATA_W'(idx) + DATA_W'(1);
    endfunction

    // State and datapath registers; reset parks the search at the full range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            key      <= '0;
            low      <= '0;
            high     <= TOP_IDX;
            addr     <= '0;
            found    <= 1'b0;
            notfound <= 1'b0;
        end else begin
            state    <= state_n;
            key      <= key_n;
            low      <= low_n;
            high     <= high_n;
            addr     <= addr_n;
            found    <= found_n;
            notfound <= notfound_n;
        end
    end

    // Next-state logic: one ROM comparison per SEARCH cycle; the mid==low/high
    // guards stop the range before it can underflow or wrap
    always_comb begin
        state_n    = state;
        key_n      = key;
        low_n      = low;
        high_n     = high;
        addr_n     = addr;
        found_n    = found;
        notfound_n = notfound;
        mid_sum    = {1'b0, low} + {1'b0, high};
        mid        = ADDR_W'(mid_sum >> 1);
        rom_val    = rom_word(mid);

        case (state)
            IDLE: begin
                if (start) begin
                    key_n   = value;
                    low_n   = '0;
                    high_n  = TOP_IDX;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (key == rom_val) begin
                    addr_n  = mid;
                    found_n = 1'b1;
                    state_n = DONE;
                end else if (key < rom_val) begin
                    if (mid == low) begin
                        notfound_n = 1'b1;
                        state_n    = DONE;
                    end else begin
                        high_n = mid - 1'b1;
                    end
                end else begin
                    if (mid == high) begin
                        notfound_n = 1'b1;
                        state_n    = DONE;
                    end else begin
                        low_n = mid + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    found_n    = 1'b0;
                    notfound_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/bsearch_lookup_seg7.sv
// Hex digit to active-low 7-segment decoder with blanking.
// Latency: combinational.
// Backpressure: none.
module seg7hex
    import bsearch_lookup_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       hide,
    output logic [6:0] leds
);

    // Decode the nibble; hide forces every segment off
    always_comb begin
        leds = SEG_BLANK;
        if (!hide) begin
            case (bcd)
                4'h0: leds = SEG_0;
                4'h1: leds = SEG_1;
                4'h2: leds = SEG_2;
                4'h3: leds = SEG_3;
                4'h4: leds = SEG_4;
                4'h5: leds = SEG_5;
                4'h6: leds = SEG_6;
                4'h7: leds = SEG_7;
                4'h8: leds = SEG_8;
                4'h9: leds = SEG_9;
                4'hA: leds = SEG_A;
                4'hB: leds = SEG_B;
                4'hC: leds = SEG_C;
                4'hD: leds = SEG_D;
                4'hE: leds = SEG_E;
                default: leds = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/bsearch_lookup_sync.sv
// Two-flop synchronizer for asynchronous switch inputs.
// Latency: 2 clk cycles.
// Backpressure: none; samples every cycle.
module series_dffs #(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] stage1;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/bsearch_lookup.sv
// Switch-driven binary search of a 32-entry ROM with hex address display.
// Latency: found/notfound at most 9 clk edges after raw start rises.
// Backpressure: result held while start stays high; dropping start rearms.
module bsearch_lookup
    import bsearch_lookup_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value_in,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic              found,
    output logic              notfound
);

    logic              start_sync;
    logic [DATA_W-1:0] value_sync;
    logic [ADDR_W-1:0] addr;
    logic              hide;
    logic [3:0]        digit_lo;
    logic [3:0]        digit_hi;

    series_dffs #(.BITS(1)) u_sync_start (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .q     (start_sync)
    );

    series_dffs #(.BITS(DATA_W)) u_sync_value (
        .clk   (clk),
        .reset (reset),
        .d     (value_in),
        .q     (value_sync)
    );

    binary_search #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_search (
        .clk      (clk),
        .reset    (reset),
        .start    (start_sync),
        .value    (value_sync),
        .addr     (addr),
        .found    (found),
        .notfound (notfound)
    );

    // The address is only meaningful on a hit, so blank otherwise
    assign hide     = ~found;
    assign digit_lo = 4'(addr);
    assign digit_hi = 4'(addr >> 4);

    seg7hex u_hex0 (
        .bcd  (digit_lo),
        .hide (hide),
        .leds (hex0)
    );

    seg7hex u_hex1 (
        .bcd  (digit_hi),
        .hide (hide),
        .leds (hex1)
    );

endmodule

// File: tb/tb_bsearch_lookup.sv
// Directed bench for bsearch_lookup with hand-computed expectations.
// Latency: checks result arrives within 9 edges of start.
// Backpressure: n/a.
module tb_bsearch_lookup;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value_in;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       found;
    logic       notfound;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] D0    = 7'b1000000;
    localparam logic [6:0] D1    = 7'b1111001;
    localparam logic [6:0] D4    = 7'b0011001;
    localparam logic [6:0] D8    = 7'b0000000;
    localparam logic [6:0] DF    = 7'b0001110;

    bsearch_lookup dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value_in (value_in),
        .hex0     (hex0),
        .hex1     (hex1),
        .found    (found),
        .notfound (notfound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; raises start and counts edges until a result appears
    task automatic run_search(input logic [7:0] v, input string tag, output int cycles);
        value_in = v;
        start    = 1'b1;
        cycles   = 0;
        while (!(found || notfound) && cycles < 12) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_latency_le9"}, 32'(cycles <= 9), 1);
        chk({tag, "_exclusive"}, 32'(found & notfound), 0);
    endtask

    task automatic release_start(input string tag);
        int n;
        start = 1'b0;
        n = 0;
        while ((found || notfound) && n < 6) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_clear_le3"}, 32'(n <= 3), 1);
        chk({tag, "_clear_found"}, 32'(found), 0);
        chk({tag, "_clear_nf"}, 32'(notfound), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        value_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_found", 32'(found), 0);
        chk("rst_nf", 32'(notfound), 0);
        chk("rst_hex0", 32'(hex0), 32'(BLANK));
        chk("rst_hex1", 32'(hex1), 32'(BLANK));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_found", 32'(found), 0);
        chk("idle_nf", 32'(notfound), 0);

        // Key 0: below the table
        run_search(8'd0, "k0", cyc);
        chk("k0_nf", 32'(notfound), 1);
        chk("k0_found", 32'(found), 0);
        chk("k0_hex0", 32'(hex0), 32'(BLANK));
        chk("k0_hex1", 32'(hex1), 32'(BLANK));
        repeat (4) @(negedge clk);
        chk("k0_hold_nf", 32'(notfound), 1);
        release_start("k0");

        // Key 33: above the table, longest path
        run_search(8'd33, "k33", cyc);
        chk("k33_nf", 32'(notfound), 1);
        chk("k33_found", 32'(found), 0);
        chk("k33_hex0", 32'(hex0), 32'(BLANK));
        chk("k33_hex1", 32'(hex1), 32'(BLANK));
        release_start("k33");

        // Key 25 -> addr 0x18; then wiggle value_in while in DONE
        run_search(8'd25, "k25", cyc);
        chk("k25_found", 32'(found), 1);
        chk("k25_nf", 32'(notfound), 0);
        chk("k25_hex1", 32'(hex1), 32'(D1));
        chk("k25_hex0", 32'(hex0), 32'(D8));
        value_in = 8'd3;
        repeat (4) @(negedge clk);
        chk("k25_hold_found", 32'(found), 1);
        chk("k25_hold_hex0", 32'(hex0), 32'(D8));
        chk("k25_hold_hex1", 32'(hex1), 32'(D1));
        release_start("k25");

        // Key 5 -> addr 4
        run_search(8'd5, "k5", cyc);
        chk("k5_found", 32'(found), 1);
        chk("k5_hex1", 32'(hex1), 32'(D0));
        chk("k5_hex0", 32'(hex0), 32'(D4));
        release_start("k5");

        // Key 16 -> addr 15 on the first SEARCH cycle (2 sync + 1 latch + 1)
        run_search(8'd16, "k16", cyc);
        chk("k16_cycles", 32'(cyc), 4);
        chk("k16_found", 32'(found), 1);
        chk("k16_hex0", 32'(hex0), 32'(DF));
        chk("k16_hex1", 32'(hex1), 32'(D0));
        release_start("k16");

        // Reset mid-search for key 33, then search key 1
        value_in = 8'd33;
        start    = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_busy_found", 32'(found | notfound), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_found", 32'(found), 0);
        chk("mid_rst_nf", 32'(notfound), 0);
        chk("mid_rst_hex0", 32'(hex0), 32'(BLANK));
        chk("mid_rst_hex1", 32'(hex1), 32'(BLANK));
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(found | notfound), 0);
        run_search(8'd1, "k1", cyc);
        chk("k1_found", 32'(found), 1);
        chk("k1_nf", 32'(notfound), 0);
        chk("k1_hex0", 32'(hex0), 32'(D0));
        chk("k1_hex1", 32'(hex1), 32'(D0));
        release_start("k1");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
